// File: rtl/sort_frame_loader.sv
// sort_frame_loader
//   Packs N consecutive DW-bit samples from a valid/ready stream into a frame.
//   The frame is presented on frame_data and a one-cycle sort_start pulse is
//   issued. The frame is then held for HOLD_CYCLES cycles before new samples
//   are accepted.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   sample present on in_data
//   in_data    in   sample value [DW-1:0]
//   in_ready   out  loader accepts a sample this cycle
//   flush      in   discard a partially filled frame (ignored while busy)
//   frame_data out  frame array [N-1:0] of DW-bit samples, to sorter data_in
//   sort_start out  one-cycle start pulse
//   busy       out  frame issued, hold window active
//   frame_cnt  out  frames issued, modulo 256
module sort_frame_loader #(
    parameter int DW          = 4,
    parameter int N           = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          flush,
    output logic [DW-1:0] frame_data [N-1:0],
    output logic          sort_start,
    output logic          busy,
    output logic [7:0]    frame_cnt
);

    localparam int IW = $clog2(N);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_idx;
    logic [HW-1:0]   r_hold_cnt;
    logic [7:0]      r_frame_cnt;
    logic [DW-1:0]   r_shadow [N-1:0];
    logic [DW-1:0]   r_frame  [N-1:0];
    logic            w_xfer;
    logic            w_last;

    // in_ready is decoded from registered state only; reset masks it so the
    // source never sees a handshake that the reset edge would swallow.
    assign in_ready   = (r_state == S_FILL) && !reset;
    assign busy       = (r_state != S_FILL);
    assign sort_start = (r_state == S_START);
    assign frame_cnt  = r_frame_cnt;
    assign frame_data = r_frame;

    assign w_xfer = in_valid && in_ready;
    assign w_last = (r_idx == IW'(N - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL:  if (!flush && w_xfer && w_last) w_next = S_START;
            S_START: w_next = S_HOLD;
            S_HOLD:  if (r_hold_cnt == '0) w_next = S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_idx       <= '0;
            r_hold_cnt  <= '0;
            r_frame_cnt <= '0;
            for (int i = 0; i < N; i++) r_frame[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FILL: begin
                    // flush wins over a simultaneous transfer; that sample is dropped
                    if (flush) begin
                        r_idx <= '0;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            // last sample bypasses the shadow buffer straight into the frame
                            for (int i = 0; i < N - 1; i++) r_frame[i] <= r_shadow[i];
                            r_frame[N-1] <= in_data;
                            r_idx        <= '0;
                            r_frame_cnt  <= r_frame_cnt + 8'd1;
                        end else begin
                            r_shadow[r_idx] <= in_data;
                            r_idx           <= r_idx + IW'(1);
                        end
                    end
                end
                S_START: r_hold_cnt <= HW'(HOLD_CYCLES - 1);
                S_HOLD:  if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - HW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;
    localparam int DW   = 4;
    localparam int N    = 4;
    localparam int HOLD = 16;

    typedef struct {
        logic [31:0] frame;
        logic [7:0]  cnt;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] frame_data [N-1:0];
    logic          sort_start;
    logic          busy;
    logic [7:0]    frame_cnt;

    sort_frame_loader #(.DW(DW), .N(N), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .frame_data(frame_data),
        .sort_start(sort_start), .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [DW-1:0] m_buf [N];
    int          m_idx = 0;
    logic [7:0]  m_cnt = 8'd0;
    logic [31:0] m_cur = 32'd0;
    int          n_ss  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_dut();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = frame_data[i];
        return v;
    endfunction

    // Called at a negedge; returns at a later negedge with in_valid low.
    task automatic send(input logic [DW-1:0] d);
        int w = 0;
        logic [31:0] f;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("ready_wait", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            m_buf[m_idx] = d;
            if (m_idx == N - 1) begin
                f = '0;
                for (int i = 0; i < N; i++) f[i*DW +: DW] = m_buf[i];
                m_cnt = m_cnt + 8'd1;
                sb.push_back('{f, m_cnt});
                m_idx = 0;
            end else begin
                m_idx++;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send4(input logic [DW-1:0] a, b, c, d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_idx = 0;
        m_cnt = 8'd0;
        m_cur = 32'd0;
        sb.delete();
        @(negedge clk);
        chk("rst_ready_low", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, sort_start}, 32'd0);
        chk("rst_frame", pack_dut(), 32'd0);
        chk("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("rst_ready_high", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    // Output monitor: scoreboard pops on sort_start, frame stability otherwise,
    // plus pulse spacing and busy / in_ready window lengths.
    logic prev_ss = 1'b0;
    logic ss_ok   = 1'b0;
    int   gap     = 0;
    int   bs_run  = 0;
    logic bs_ok   = 1'b0;
    int   ir_run  = 0;
    logic ir_ok   = 1'b0;

    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (sort_start) begin
            n_ss++;
            if (prev_ss) chk("start_twice", 32'd1, 32'd0);
            if (ss_ok) chk("start_gap", {31'd0, (gap + 1) >= (N + HOLD + 1)}, 32'd1);
            ss_ok = 1'b1;
            gap   = 0;
            if (sb.size() == 0) begin
                chk("unexpected_start", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("frame", pack_dut(), e.frame);
                chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, e.cnt});
                m_cur = e.frame;
            end
        end else begin
            gap++;
            chk("stable", pack_dut(), m_cur);
        end
        if (reset) ss_ok = 1'b0;
        prev_ss = sort_start;

        if (busy) begin
            if (bs_run == 0) bs_ok = 1'b1;
            bs_run++;
        end else if (bs_run != 0) begin
            if (bs_ok && !reset) chk("busy_len", bs_run, HOLD + 1);
            bs_run = 0;
        end
        if (reset) bs_ok = 1'b0;

        if (!in_ready) begin
            if (ir_run == 0) ir_ok = !reset;
            else if (reset) ir_ok = 1'b0;
            ir_run++;
        end else begin
            if (ir_run != 0 && ir_ok) chk("ready_low_len", ir_run, HOLD + 1);
            ir_run = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_ready", {31'd0, in_ready}, 32'd0);
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_start", {31'd0, sort_start}, 32'd0);
        chk("init_frame", pack_dut(), 32'd0);
        chk("init_cnt", {24'd0, frame_cnt}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("init_ready_up", {31'd0, in_ready}, 32'd1);

        // basic frame, then frame 2 while the monitor checks stability
        send4(4'd5, 4'd8, 4'd11, 4'd6);
        send4(4'd10, 4'd0, 4'd15, 4'd1);

        // gaps, then 12 presented during HOLD becomes slot 0 of the next frame
        send(4'd3);
        @(negedge clk);
        send(4'd9);
        repeat (2) @(negedge clk);
        send(4'd1);
        send(4'd7);
        send4(4'd12, 4'd13, 4'd14, 4'd15);

        // flush in FILL drops the partial frame and the concurrent sample
        send(4'd2);
        send(4'd4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd15;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        m_idx    = 0;
        send4(4'd1, 4'd2, 4'd3, 4'd4);

        // flush during HOLD is ignored
        @(negedge clk);
        flush = 1'b1;
        repeat (6) @(negedge clk);
        flush = 1'b0;
        send4(4'd9, 4'd9, 4'd0, 4'd3);

        // reset mid-HOLD
        send4(4'd7, 4'd6, 4'd5, 4'd4);
        repeat (3) @(negedge clk);
        do_reset();

        // reset after two samples, then a complete frame
        send(4'd11);
        send(4'd12);
        do_reset();
        send4(4'd8, 4'd3, 4'd14, 4'd2);

        // counter wrap over 256 frames
        do_reset();
        p0 = n_ss;
        for (int k = 1; k <= 256; k++) begin
            send4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (k == 255) chk("cnt_255", {24'd0, frame_cnt}, 32'd255);
        end
        repeat (HOLD + 4) @(negedge clk);
        chk("cnt_wrap", {24'd0, frame_cnt}, 32'd0);
        chk("start_pulses", n_ss - p0, 32'd256);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
